// File: rtl/nec_pkg.sv
// Shared types for the NEC command decoder: FSM states, the captured frame
// layout and the per-byte bit reversal used at capture time.
package nec_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, PENDING} nec_state_e;

  // Bytes stored in NEC order (bit0 = first transmitted bit).
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] addrInv;
    logic [7:0] cmd;
    logic [7:0] cmdInv;
  } nec_frame_t;

  // The receiver shifts the first bit into the byte MSB; NEC sends LSB first.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/nec_holdoff_timer.sv
// Hold-off window timer: reloads on every accepted frame, counts down to zero
// and stays there. "Running" means the window has not yet elapsed.
module nec_holdoff_timer #(
  parameter int unsigned LOAD_VAL = 6_000_000
) (
  input  logic clkIN,
  input  logic nResetIN,
  input  logic loadIN,
  output logic runningOUT
);

  localparam int unsigned W = $clog2(LOAD_VAL + 1);
  localparam logic [W-1:0] LOAD_W = LOAD_VAL[W-1:0];
  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count;

  // Saturating down-counter; reset leaves the window expired.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN)          count <= '0;
    else if (loadIN)        count <= LOAD_W;
    else if (count != '0)   count <= count - ONE_W;
  end

  assign runningOUT = (count != '0);

endmodule

// File: rtl/nec_command_decoder.sv
// NEC command decoder: validates complement bytes, filters by device address,
// tags repeats inside the hold-off window and offers commands over valid/ready.
// Build option: NEC_EXTENDED_ADDR_EN selects 16-bit extended addressing
// (no address complement check, full 16-bit address compare).
module nec_command_decoder
  import nec_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED = 50_000_000,
  parameter int unsigned HOLDOFF_MS  = 120,
  parameter logic [15:0] DEVICE_ADDR = 16'h00FF,
  parameter bit          ADDR_FILTER = 1'b1
) (
  input  logic        clkIN,
  input  logic        nResetIN,
  input  logic        dataReceivedIN,
  input  logic [31:0] dataIN,
  input  logic        cmdReadyIN,
  output logic        cmdValidOUT,
  output logic [7:0]  cmdOUT,
  output logic [15:0] addrOUT,
  output logic        repeatOUT,
  output logic        errorOUT,
  output logic        overflowOUT
);

  localparam int unsigned HOLDOFF_CYCLES = CLOCK_SPEED / 1000 * HOLDOFF_MS;

  nec_state_e state, stateNext;
  nec_frame_t frame;
  logic [7:0] lastCmd;
  logic [15:0] addrFull;
  logic errCmd, errAddr, addrMatch, dropAddr;
  logic captureEn, loadOut, errSet, ovfSet, timerRunning;

  nec_holdoff_timer #(.LOAD_VAL(HOLDOFF_CYCLES)) uTimer (
    .clkIN      (clkIN),
    .nResetIN   (nResetIN),
    .loadIN     (loadOut),
    .runningOUT (timerRunning)
  );

  assign errCmd = (frame.cmd != ~frame.cmdInv);

`ifdef NEC_EXTENDED_ADDR_EN
  assign errAddr   = 1'b0;
  assign addrFull  = {frame.addrInv, frame.addr};
  assign addrMatch = (addrFull == DEVICE_ADDR);
`else
  assign errAddr   = (frame.addr != ~frame.addrInv);
  assign addrFull  = {8'h00, frame.addr};
  assign addrMatch = (frame.addr == DEVICE_ADDR[7:0]);
`endif

  assign dropAddr    = ADDR_FILTER && !addrMatch;
  assign cmdValidOUT = (state == PENDING);

  // State register.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) state <= IDLE;
    else           state <= stateNext;
  end

  // Next state and datapath strobes.
  always_comb begin
    stateNext = state;
    captureEn = 1'b0;
    loadOut   = 1'b0;
    errSet    = 1'b0;
    ovfSet    = 1'b0;
    case (state)
      IDLE: begin
        if (dataReceivedIN) begin
          captureEn = 1'b1;
          stateNext = CHECK;
        end
      end
      CHECK: begin
        // A pulse here is ignored: capture only happens in IDLE/PENDING.
        if (errCmd || errAddr) begin
          errSet    = 1'b1;
          stateNext = IDLE;
        end else if (dropAddr) begin
          stateNext = IDLE;
        end else begin
          loadOut   = 1'b1;
          stateNext = PENDING;
        end
      end
      PENDING: begin
        // A new frame wins; it only counts as overflow if the old one was not
        // taken in the same cycle.
        if (dataReceivedIN) begin
          captureEn = 1'b1;
          ovfSet    = !cmdReadyIN;
          stateNext = CHECK;
        end else if (cmdReadyIN) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture register, output register, last-command register and flags.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      frame       <= '0;
      lastCmd     <= '0;
      cmdOUT      <= '0;
      addrOUT     <= '0;
      repeatOUT   <= 1'b0;
      errorOUT    <= 1'b0;
      overflowOUT <= 1'b0;
    end else begin
      errorOUT <= errSet;
      if (ovfSet) overflowOUT <= 1'b1;
      if (captureEn) begin
        frame <= '{addr:    bit_rev8(dataIN[31:24]),
                   addrInv: bit_rev8(dataIN[23:16]),
                   cmd:     bit_rev8(dataIN[15:8]),
                   cmdInv:  bit_rev8(dataIN[7:0])};
      end
      if (loadOut) begin
        cmdOUT    <= frame.cmd;
        addrOUT   <= addrFull;
        repeatOUT <= (frame.cmd == lastCmd) && timerRunning;
        lastCmd   <= frame.cmd;
      end
    end
  end

endmodule

// File: tb/tb_nec_command_decoder.sv
// Directed bench for nec_command_decoder (standard addressing build).
// dutA accepts any address; dutF filters on device address 0x0004.
// Clock scaled to 10 kHz so 1 ms = 10 cycles, hold-off 120 ms = 1200 cycles.
module tb_nec_command_decoder;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        dRx = 1'b0;
  logic [31:0] dIn = '0;
  logic        rdy = 1'b0;

  logic        vA, rA, eA, oA, vF, rF, eF, oF;
  logic [7:0]  cA, cF;
  logic [15:0] aA, aF;

  int chk = 0;
  int pass = 0;

  // Raw frames (receiver order). F1: addr 0x04 cmd 0x12; B: addr 0x04 cmd 0x34.
  localparam logic [31:0] FR_ZERO = 32'h00FF_00FF;
  localparam logic [31:0] FR_ERR  = 32'h20DF_0000;
  localparam logic [31:0] FR_A05  = 32'hA05F_48B7;
  localparam logic [31:0] FR_F1   = 32'h20DF_48B7;
  localparam logic [31:0] FR_B    = 32'h20DF_2CD3;

  always #5 clk = ~clk;

  nec_command_decoder #(.CLOCK_SPEED(10_000), .HOLDOFF_MS(120),
                        .DEVICE_ADDR(16'h00FF), .ADDR_FILTER(1'b0)) dutA (
    .clkIN(clk), .nResetIN(nRst), .dataReceivedIN(dRx), .dataIN(dIn),
    .cmdReadyIN(rdy), .cmdValidOUT(vA), .cmdOUT(cA), .addrOUT(aA),
    .repeatOUT(rA), .errorOUT(eA), .overflowOUT(oA));

  nec_command_decoder #(.CLOCK_SPEED(10_000), .HOLDOFF_MS(120),
                        .DEVICE_ADDR(16'h0004), .ADDR_FILTER(1'b1)) dutF (
    .clkIN(clk), .nResetIN(nRst), .dataReceivedIN(dRx), .dataIN(dIn),
    .cmdReadyIN(rdy), .cmdValidOUT(vF), .cmdOUT(cF), .addrOUT(aF),
    .repeatOUT(rF), .errorOUT(eF), .overflowOUT(oF));

  // One-cycle receive pulse; returns 1 ns after the edge that sampled it.
  task automatic sendFrame(input logic [31:0] f);
    @(posedge clk); #1;
    dIn = f; dRx = 1'b1;
    @(posedge clk); #1;
    dRx = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nRst = 1'b0; rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk++; if ({vA, cA, aA, rA, eA, oA} !== '0) $display("FAIL reset_A got %h exp 0", {vA, cA, aA, rA, eA, oA}); else pass++;
    chk++; if ({vF, cF, aF, rF, eF, oF} !== '0) $display("FAIL reset_F got %h exp 0", {vF, cF, aF, rF, eF, oF}); else pass++;
    nRst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    rdy = 1'b1;
    sendFrame(FR_ZERO);
    chk++; if (vA !== 1'b0) $display("FAIL basic_valid_n1 got %b exp 0", vA); else pass++;
    step();
    chk++; if (vA !== 1'b1) $display("FAIL basic_valid_n2 got %b exp 1", vA); else pass++;
    chk++; if (cA !== 8'h00) $display("FAIL basic_cmd got %h exp 00", cA); else pass++;
    chk++; if (aA !== 16'h0000) $display("FAIL basic_addr got %h exp 0000", aA); else pass++;
    chk++; if (rA !== 1'b0) $display("FAIL basic_repeat got %b exp 0", rA); else pass++;
    chk++; if (vF !== 1'b0) $display("FAIL basic_filtered_valid got %b exp 0", vF); else pass++;
    step();
    chk++; if (vA !== 1'b0) $display("FAIL basic_valid_n3 got %b exp 0", vA); else pass++;
  endtask

  task automatic test_error();
    rdy = 1'b1;
    sendFrame(FR_ERR);
    step();
    chk++; if (eF !== 1'b1) $display("FAIL err_pulse got %b exp 1", eF); else pass++;
    chk++; if (vF !== 1'b0) $display("FAIL err_valid got %b exp 0", vF); else pass++;
    step();
    chk++; if (eF !== 1'b0) $display("FAIL err_pulse_end got %b exp 0", eF); else pass++;
    chk++; if (vF !== 1'b0 || vA !== 1'b0) $display("FAIL err_valid_after got %b%b exp 00", vA, vF); else pass++;
  endtask

  task automatic test_filter();
    rdy = 1'b1;
    sendFrame(FR_A05);
    step();
    chk++; if ({vF, eF} !== 2'b00) $display("FAIL filter_drop got %b exp 00", {vF, eF}); else pass++;
    chk++; if (vA !== 1'b1) $display("FAIL filter_anyaddr_valid got %b exp 1", vA); else pass++;
    chk++; if (aA !== 16'h0005) $display("FAIL filter_anyaddr_addr got %h exp 0005", aA); else pass++;
    chk++; if (cA !== 8'h12) $display("FAIL filter_anyaddr_cmd got %h exp 12", cA); else pass++;
    step();
    chk++; if (vF !== 1'b0) $display("FAIL filter_drop_later got %b exp 0", vF); else pass++;
  endtask

  task automatic test_repeat();
    rdy = 1'b1;
    sendFrame(FR_F1);
    step();
    chk++; if ({vF, rF, cF, aF} !== {2'b10, 8'h12, 16'h0004}) $display("FAIL rep_first got %b%b %h %h exp 10 12 0004", vF, rF, cF, aF); else pass++;
    repeat (500) @(posedge clk);
    sendFrame(FR_F1);
    step();
    chk++; if ({vF, rF} !== 2'b11) $display("FAIL rep_50ms got %b exp 11", {vF, rF}); else pass++;
    repeat (2000) @(posedge clk);
    sendFrame(FR_F1);
    step();
    chk++; if ({vF, rF} !== 2'b10) $display("FAIL rep_200ms got %b exp 10", {vF, rF}); else pass++;
    step();
  endtask

  task automatic test_overflow();
    rdy = 1'b0;
    sendFrame(FR_F1);
    step();
    chk++; if ({vF, oF} !== 2'b10) $display("FAIL ovf_first_pending got %b exp 10", {vF, oF}); else pass++;
    sendFrame(FR_B);
    chk++; if ({vF, oF} !== 2'b01) $display("FAIL ovf_set got %b exp 01", {vF, oF}); else pass++;
    step();
    chk++; if ({vF, cF, rF} !== {1'b1, 8'h34, 1'b0}) $display("FAIL ovf_cmd_b got %b %h %b exp 1 34 0", vF, cF, rF); else pass++;
    step();
    chk++; if (vF !== 1'b1) $display("FAIL ovf_hold got %b exp 1", vF); else pass++;
    rdy = 1'b1;
    step();
    chk++; if ({vF, oF} !== 2'b01) $display("FAIL ovf_accept got %b exp 01", {vF, oF}); else pass++;
  endtask

  task automatic test_reset_pending();
    rdy = 1'b0;
    sendFrame(FR_F1);
    step();
    chk++; if (vF !== 1'b1) $display("FAIL rstp_pending got %b exp 1", vF); else pass++;
    nRst = 1'b0;
    #1;
    chk++; if ({vF, cF, aF, rF, eF, oF} !== '0) $display("FAIL rstp_async got %h exp 0", {vF, cF, aF, rF, eF, oF}); else pass++;
    @(negedge clk);
    nRst = 1'b1;
    rdy = 1'b1;
    sendFrame(FR_F1);
    step();
    chk++; if ({vF, cF, rF} !== {1'b1, 8'h12, 1'b0}) $display("FAIL rstp_next got %b %h %b exp 1 12 0", vF, cF, rF); else pass++;
    step();
  endtask

  task automatic test_back_to_back();
    rdy = 1'b1;
    sendFrame(FR_F1);
    // next pulse lands in the first PENDING cycle, with ready high
    sendFrame(FR_B);
    chk++; if ({vF, oF} !== 2'b00) $display("FAIL b2b_accept got %b exp 00", {vF, oF}); else pass++;
    step();
    chk++; if ({vF, cF, rF} !== {1'b1, 8'h34, 1'b0}) $display("FAIL b2b_second got %b %h %b exp 1 34 0", vF, cF, rF); else pass++;
    step();
    chk++; if (vF !== 1'b0) $display("FAIL b2b_done got %b exp 0", vF); else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_filter();
    test_repeat();
    test_overflow();
    test_reset_pending();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
